// File: rtl/divisor_frecuencia_multicanal.sv
// Multi-channel programmable clock divider.
// Each channel produces a 50% duty square wave plus a one-cycle tick on every
// toggle. Each channel has its own enable. New limits are staged as pending
// values and only take effect at a wrap or while the channel is disabled, so a
// half-period never changes part-way through. A global sync strobe re-aligns
// the phase of every channel.
module divisor_frecuencia_multicanal #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 25,
  parameter int unsigned DEF_LIMIT = 25000000,
  parameter int unsigned OUT_INIT  = 1,
  parameter int unsigned SEL_W     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [CNT_W-1:0]  wr_data,
  output logic              wr_ack,
  output logic [NUM_CH-1:0] wr_pend,
  output logic [NUM_CH-1:0] out_clk,
  output logic [NUM_CH-1:0] out_tick
);

  localparam logic [CNT_W-1:0] DEF_LIM_C  = CNT_W'(DEF_LIMIT);
  localparam logic             OUT_INIT_C = 1'(OUT_INIT);

  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [CNT_W-1:0]  lim_q  [NUM_CH];
  logic [CNT_W-1:0]  lim_d  [NUM_CH];
  logic [CNT_W-1:0]  pval_q [NUM_CH];
  logic [CNT_W-1:0]  pval_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] out_q, out_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic              ack_q, ack_d;
  logic              wr_ok;

  // Next-state logic for the write port and for every channel's counter.
  always_comb begin
    cnt_d  = cnt_q;
    lim_d  = lim_q;
    pval_d = pval_q;
    pend_d = pend_q;
    out_d  = out_q;
    tick_d = '0;
    wr_ok  = wr_en && (32'(wr_sel) < 32'(NUM_CH));
    ack_d  = wr_ok;

    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sync) begin
        // Phase alignment overrides any coincident wrap, and it also commits
        // any staged limit.
        cnt_d[i] = '0;
        out_d[i] = OUT_INIT_C;
        if (pend_q[i]) begin
          lim_d[i]  = pval_q[i];
          pend_d[i] = 1'b0;
        end
      end else if (en[i]) begin
        if (cnt_q[i] == lim_q[i]) begin
          cnt_d[i]  = '0;
          out_d[i]  = ~out_q[i];
          tick_d[i] = 1'b1;
          if (pend_q[i]) begin
            lim_d[i]  = pval_q[i];
            pend_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else if (pend_q[i]) begin
        // An idle channel can take a new limit at once. Its output does not
        // change.
        lim_d[i]  = pval_q[i];
        pend_d[i] = 1'b0;
      end

      // A write is handled after the apply logic. A write that lands on the
      // same cycle as a wrap or sync therefore stays pending until the next
      // apply point.
      if (wr_ok && (32'(wr_sel) == i)) begin
        pval_d[i] = wr_data;
        pend_d[i] = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset. Reset also discards staged writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        lim_q[i]  <= DEF_LIM_C;
        pval_q[i] <= DEF_LIM_C;
      end
      pend_q <= '0;
      out_q  <= {NUM_CH{OUT_INIT_C}};
      tick_q <= '0;
      ack_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lim_q  <= lim_d;
      pval_q <= pval_d;
      pend_q <= pend_d;
      out_q  <= out_d;
      tick_q <= tick_d;
      ack_q  <= ack_d;
    end
  end

  assign wr_ack   = ack_q;
  assign wr_pend  = pend_q;
  assign out_clk  = out_q;
  assign out_tick = tick_q;

endmodule

// File: doc/divisor_frecuencia_multicanal.md
Name: divisor_frecuencia_multicanal

Overview:
- Parametrised, runtime-programmable clock divider with NUM_CH independent channels.
- Each channel produces a 50% duty square wave and a one-cycle tick from a shared system clock.
- Channels support individual enable, glitch-free divisor reprogramming at terminal count, and global phase alignment.
- Feeds display multiplexing, blink and debounce timing logic.

Parameters:
- NUM_CH, 4, number of divider channels (1..16).
- CNT_W, 25, counter and limit width in bits.
- DEF_LIMIT, 25000000, reset value of every channel limit (half-period = DEF_LIMIT+1 clk cycles).
- OUT_INIT, 1, reset and sync level of every out_clk bit.
- SEL_W, 2, channel select width; must satisfy 2**SEL_W >= NUM_CH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  NUM_CH  per-channel count enable.
- sync  input  1  synchronous phase-align strobe for all channels.
- wr_en  input  1  limit write strobe.
- wr_sel  input  SEL_W  target channel of write.
- wr_data  input  CNT_W  new limit value.
- wr_ack  output  1  one-cycle pulse, write accepted.
- wr_pend  output  NUM_CH  a written limit is waiting to be applied.
- out_clk  output  NUM_CH  divided square waves.
- out_tick  output  NUM_CH  one-cycle pulse at each out_clk toggle.

Behaviour:
- Reset (async, while reset=1):
  - All counters = 0; active and pending limits = DEF_LIMIT.
  - out_clk = all OUT_INIT; out_tick = 0; wr_ack = 0; wr_pend = 0.
- Per channel i, each clk edge with en[i]=1 and sync=0:
  - If cnt==lim: cnt<=0, out_clk[i] toggles, out_tick[i]=1 this cycle (registered, aligned with the toggle edge).
  - If pend[i]: lim<=pend_val, pend[i]<=0.
  - Else: cnt<=cnt+1.
- Half-period = lim+1 cycles; full period = 2*(lim+1). lim=0 gives clk/2 with a tick every cycle.
- en[i]=0: counter, out_clk[i] and limits hold; out_tick[i]=0.
- Disabled channel with pending limit: applies it on the next cycle without toggling.
- Writes:
  - wr_en=1 with wr_sel<NUM_CH stores wr_data in pend_val[wr_sel] and sets wr_pend[wr_sel] next cycle; wr_ack=1 next cycle.
  - wr_sel>=NUM_CH: ignored, no ack, no state change.
  - A second write before apply overwrites pend_val; wr_pend stays 1.
- Write in the same cycle as a wrap on that channel: the wrap uses the previously active/pending value; the new value stays pending until the next wrap.
- Glitch-free: lim never changes mid half-period while enabled, so no runt pulses.
- sync=1 (all channels, regardless of en):
  - cnt<=0, out_clk<=OUT_INIT, out_tick=0.
  - Pending limits apply and wr_pend clears.
  - sync overrides a coincident wrap.
  - A write coincident with sync is taken as pending after the sync.
- Counter compare uses equality only. If lim is lowered to below the current cnt, that cannot occur because apply happens only at wrap or while disabled.
- Reset mid-operation aborts any pending write and discards pending values.

Test Plan:
- Reset, NUM_CH=2, DEF_LIMIT=3, en=11 -> out_clk toggles every 4 cycles (period 8); out_tick pulses every 4th cycle; first toggle 4 cycles after reset release.
- Write wr_sel=1 wr_data=1 mid half-period -> wr_ack pulse next cycle; wr_pend[1]=1 until the current half-period ends. Then half-period becomes 2 cycles with no short pulse.
- en[0]=0 for 5 cycles mid-count -> out_clk[0] frozen, no ticks; resumes with the remaining count (total half-period = 4 enabled cycles).
- Assert sync while channels are at different phases -> next cycle all cnt=0 and out_clk=OUT_INIT. Pending limits apply and wr_pend=0; channels then toggle in lockstep.
- Write with wr_sel=3 when NUM_CH=2 -> no wr_ack, wr_pend unchanged. Write coincident with a wrap -> new limit applies at the following wrap.
- Assert reset asynchronously between clk edges with wr_pend=1 -> outputs return immediately to reset values; limit = DEF_LIMIT.
